dpd_ovf_guard: RTL
==================

Name: dpd_ovf_guard

Overview:
- Sits directly downstream of the memory-polynomial DPD top, between its 128-bit lane-packed output and the JESD TX transport.
- Saturates every predistorted I/Q component to a programmable clip level and counts clipping events over a sliding-free fixed window.
- When clipping is excessive, falls back to the raw (bypass) baseband for a hold-off period, then re-arms.
- Reports sticky clip statistics and an overflow LED.

Parameters:
- CLIP_LEVEL, 16383, positive saturation limit per 16-bit component; the negative limit is -CLIP_LEVEL.
- WIN_LEN, 4096, observation window length in cycles (>=2).
- TRIP_THR, 64, clip-cycles within one window that trip the guard (1..WIN_LEN).
- HOLDOFF, 65536, cycles spent in bypass after a trip (>=1).

Ports:
- JESD_clk_i  in  1  single clock for all logic.
- reset_ni  in  1  asynchronous, active-low reset.
- dpd_i  in  128  DPD output, lane-packed.
- byp_i  in  128  raw baseband, same packing, time-aligned with dpd_i.
- wdpd_req_i  in  1  software/VIO request to use DPD output.
- data_o  out  128  guarded output, same packing.
- state_o  out  2  0=IDLE, 1=ACTIVE, 2=TRIPPED.
- trip_o  out  1  one-cycle pulse on entry to TRIPPED.
- trip_cnt_o  out  16  number of trips, saturating.
- clip_cnt_o  out  32  total clip cycles seen in ACTIVE, saturating.
- ovf_led_o  out  1  sticky; set on any clip, cleared by reset or a rising edge of wdpd_req_i.

Behaviour:
- Packing, for sample k=0..3:
  - I_k = {d[8k+:8], d[32+8k+:8]}
  - Q_k = {d[64+8k+:8], d[96+8k+:8]}
  - The same layout applies to dpd_i, byp_i and data_o.
- Reset (async assert, sync deassert handled upstream):
  - data_o=0, state_o=IDLE, trip_o=0.
  - All counters=0, ovf_led_o=0.
  - Pipeline registers=0.
- Pipeline, fixed 2-cycle latency on both paths:
  - Stage 1 registers dpd_i, byp_i.
  - Stage 2 saturates the 8 signed components, muxes on the current state, and registers data_o.
  - An input sampled at edge n appears on data_o after edge n+2.
- Clip flag:
  - Combinational from stage 1.
  - Asserted when any component is > CLIP_LEVEL or < -CLIP_LEVEL.
  - -32768 counts as a clip.
  - Saturation replaces the component with ±CLIP_LEVEL of the same sign; other components pass unchanged.
- States:
  - IDLE:
    - data_o = bypass path.
    - Window counters held at 0.
    - Goes to ACTIVE when wdpd_req_i=1.
  - ACTIVE:
    - data_o = saturated DPD path.
    - wcnt counts 0..WIN_LEN-1 and wraps; ccnt increments on each clip cycle.
    - If the clip flag is set and ccnt+1 == TRIP_THR, at that edge: go to TRIPPED, pulse trip_o, increment trip_cnt_o.
    - The tripping beat itself is still output as saturated DPD.
    - When wcnt wraps without a trip, ccnt clears. On the wrap cycle with a clip and no trip, ccnt loads 0 (the clip is counted in the old window only).
  - TRIPPED:
    - data_o = bypass path.
    - hcnt counts HOLDOFF cycles.
    - On expiry: wcnt=ccnt=0, then go to ACTIVE if wdpd_req_i=1, else IDLE.
- wdpd_req_i=0 in any state: go to IDLE at the next edge and clear hcnt, wcnt and ccnt. This is the priority over all other transitions.
- Mux select is the state register value before the edge that loads data_o. Consequence: a switch affects the beat loaded at that edge, with no partial-sample mixing.
- clip_cnt_o: increments only in ACTIVE; saturates at 2^32-1.
- trip_cnt_o: saturates at 65535.
- Reset mid-operation: immediate return to IDLE with all values as at reset; no residual hold-off.

Test Plan (WIN_LEN=16, TRIP_THR=4, HOLDOFF=8, CLIP_LEVEL=16383):
1. Reset low, then wdpd_req_i=1, dpd_i with I_0=0x1234 and all others 0. Expect: state ACTIVE after 1 edge; data_o I_0=0x1234 exactly 2 cycles after input; ovf_led_o=0.
2. One beat with I_2=0x5000 and Q_3=0x8000 in ACTIVE. Expect: data_o I_2=0x3FFF and Q_3=0xC001; clip_cnt_o=1; ovf_led_o=1.
3. Four clip beats in one window. Expect: trip_o pulses on the 4th; the 4th beat is still saturated DPD; the 5th output beat equals byp_i; trip_cnt_o=1; after 8 bypass cycles, back to ACTIVE.
4. Three clip beats, then the window wraps, then three more clip beats. Expect: no trip; clip_cnt_o=6.
5. wdpd_req_i dropped mid-TRIPPED. Expect: IDLE next edge. Re-raise wdpd_req_i. Expect: ACTIVE with ccnt=0; ovf_led_o cleared.
6. reset_ni asserted asynchronously mid-window. Expect: data_o=0 and state_o=0 without a clock edge; all counters 0.

Source files
------------

// File: rtl/dpd_ovf_guard_if.sv
// -----------------------------------------------------------------------------
// dpd_ovf_guard_if
//
// Purpose:
//   Bundles the data and status signals of the DPD overflow guard. This covers
//   both sample streams (DPD output and raw bypass baseband), the DPD request,
//   the guarded output stream and the clip/trip statistics. Clock and reset
//   stay outside the bundle as plain ports of the guard.
//
// Signals (directions as seen by the guard, i.e. the slave modport):
//   dpd_i       in  128  DPD output, lane-packed (see dpd_ovf_guard header)
//   byp_i       in  128  raw baseband, same packing, time-aligned with dpd_i
//   wdpd_req_i  in    1  request to use the DPD output
//   data_o      out 128  guarded output, same packing
//   state_o     out   2  0=IDLE, 1=ACTIVE, 2=TRIPPED
//   trip_o      out   1  one-cycle pulse on entry to TRIPPED
//   trip_cnt_o  out  16  number of trips, saturating
//   clip_cnt_o  out  32  clip cycles seen in ACTIVE, saturating
//   ovf_led_o   out   1  sticky clip indicator
//
// Modports:
//   master - the surrounding logic / testbench that drives the streams
//   slave  - the guard itself
// -----------------------------------------------------------------------------
interface dpd_ovf_guard_if;
  logic [127:0] dpd_i;
  logic [127:0] byp_i;
  logic         wdpd_req_i;
  logic [127:0] data_o;
  logic [1:0]   state_o;
  logic         trip_o;
  logic [15:0]  trip_cnt_o;
  logic [31:0]  clip_cnt_o;
  logic         ovf_led_o;

  modport master (
    output dpd_i,
    output byp_i,
    output wdpd_req_i,
    input  data_o,
    input  state_o,
    input  trip_o,
    input  trip_cnt_o,
    input  clip_cnt_o,
    input  ovf_led_o
  );

  modport slave (
    input  dpd_i,
    input  byp_i,
    input  wdpd_req_i,
    output data_o,
    output state_o,
    output trip_o,
    output trip_cnt_o,
    output clip_cnt_o,
    output ovf_led_o
  );
endinterface

// File: rtl/dpd_ovf_guard.sv
// -----------------------------------------------------------------------------
// dpd_ovf_guard
//
// Purpose:
//   This block sits between the memory-polynomial DPD output and the JESD TX
//   transport. It saturates every predistorted I/Q component to +/-CLIP_LEVEL
//   and counts clip cycles in fixed (non-sliding) windows of WIN_LEN cycles.
//   If TRIP_THR clip cycles land in one window, the output falls back to the
//   raw bypass baseband for HOLDOFF cycles and then re-arms.
//
// Lane packing (same for dpd_i, byp_i and data_o), sample k = 0..3:
//   I_k = {d[8k +: 8],    d[32+8k +: 8]}
//   Q_k = {d[64+8k +: 8], d[96+8k +: 8]}
//
// Ports:
//   JESD_clk_i  in   single clock for all logic
//   reset_ni    in   asynchronous active-low reset
//   bus         slave modport of dpd_ovf_guard_if (streams + statistics)
//
// Timing:
//   Two register stages on both paths. Stage 1 registers dpd_i/byp_i.
//   Stage 2 saturates, selects on the current state and registers data_o.
//   The clip flag is decoded from stage 1. The state update therefore
//   judges the same beat that stage 2 is loading at that edge.
// -----------------------------------------------------------------------------
module dpd_ovf_guard #(
  parameter int          CLIP_LEVEL = 16383,
  parameter int unsigned WIN_LEN    = 4096,
  parameter int unsigned TRIP_THR   = 64,
  parameter int unsigned HOLDOFF    = 65536
) (
  input  logic           JESD_clk_i,
  input  logic           reset_ni,
  dpd_ovf_guard_if.slave bus
);

  // ---------------------------------------------------------------------------
  // State encoding and counter geometry
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACTIVE  = 2'd1;
  localparam logic [1:0] S_TRIPPED = 2'd2;

  localparam int WCNT_W = (WIN_LEN  > 1) ? $clog2(WIN_LEN)    : 1;
  localparam int HCNT_W = (HOLDOFF  > 1) ? $clog2(HOLDOFF)    : 1;
  localparam int CCNT_W = $clog2(TRIP_THR + 1);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN_LEN - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLDOFF - 1);
  // ccnt holds clips already seen in the window. A clip arriving while
  // ccnt == TRIP_THR-1 is the one that reaches the threshold.
  localparam logic [CCNT_W-1:0] CCNT_TRIP = CCNT_W'(TRIP_THR - 1);

  localparam logic signed [15:0] POS_LIM = 16'(CLIP_LEVEL);
  localparam logic signed [15:0] NEG_LIM = -POS_LIM;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [127:0]      dpd_q, dpd_d;
  logic [127:0]      byp_q, byp_d;
  logic [127:0]      data_q, data_d;
  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CCNT_W-1:0] ccnt_q, ccnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              trip_q, trip_d;
  logic [15:0]       trip_cnt_q, trip_cnt_d;
  logic [31:0]       clip_cnt_q, clip_cnt_d;
  logic              ovf_led_q, ovf_led_d;
  logic              req_q, req_d;

  // ---------------------------------------------------------------------------
  // Stage 1 next-state: plain capture of both streams and the request
  // ---------------------------------------------------------------------------
  always_comb begin
    dpd_d = bus.dpd_i;
    byp_d = bus.byp_i;
    req_d = bus.wdpd_req_i;
  end

  // ---------------------------------------------------------------------------
  // Per-component clip detect and saturation on the stage-1 DPD beat.
  // Components 0..3 are I_0..I_3, components 4..7 are Q_0..Q_3.
  // ---------------------------------------------------------------------------
  logic [7:0]   comp_clip;
  logic [127:0] dpd_sat;
  logic         clip_flag;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_comp
      localparam int HI = 64 * (gi / 4) + 8 * (gi % 4);
      localparam int LO = HI + 32;

      logic signed [15:0] comp;
      logic signed [15:0] sat;

      assign comp = {dpd_q[HI +: 8], dpd_q[LO +: 8]};

      // Symmetric limit: -32768 lies below -CLIP_LEVEL and counts as a clip.
      assign comp_clip[gi] = (comp > POS_LIM) || (comp < NEG_LIM);

      always_comb begin
        sat = comp;
        if (comp > POS_LIM) begin
          sat = POS_LIM;
        end else if (comp < NEG_LIM) begin
          sat = NEG_LIM;
        end
      end

      assign dpd_sat[HI +: 8] = sat[15:8];
      assign dpd_sat[LO +: 8] = sat[7:0];
    end
  endgenerate

  assign clip_flag = |comp_clip;

  // ---------------------------------------------------------------------------
  // Stage 2 output select. The state register selects the path, not its
  // next value. A state change takes effect on the whole beat loaded at the
  // edge that follows the change, so no sample is ever mixed.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d = byp_q;
    if (state_q == S_ACTIVE) begin
      data_d = dpd_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky LED: a rising edge of the request acknowledges and clears it. The
  // clear wins over a clip seen in the same cycle, so the acknowledge always
  // takes effect.
  // ---------------------------------------------------------------------------
  logic req_rise;
  assign req_rise = bus.wdpd_req_i & ~req_q;

  always_comb begin
    ovf_led_d = ovf_led_q;
    if (req_rise) begin
      ovf_led_d = 1'b0;
    end else if (clip_flag) begin
      ovf_led_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lifetime clip statistics: only beats actually sent as DPD are counted.
  // ---------------------------------------------------------------------------
  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if ((state_q == S_ACTIVE) && clip_flag && (clip_cnt_q != 32'hFFFF_FFFF)) begin
      clip_cnt_d = clip_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Guard FSM with window / clip / hold-off counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    ccnt_d     = ccnt_q;
    hcnt_d     = hcnt_q;
    trip_d     = 1'b0;
    trip_cnt_d = trip_cnt_q;

    if (!bus.wdpd_req_i) begin
      // Dropping the request overrides everything and forgets all progress.
      state_d = S_IDLE;
      wcnt_d  = '0;
      ccnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACTIVE;
          wcnt_d  = '0;
          ccnt_d  = '0;
          hcnt_d  = '0;
        end

        S_ACTIVE: begin
          if (clip_flag && (ccnt_q == CCNT_TRIP)) begin
            // Tripping has priority over a window wrap on the same edge.
            state_d = S_TRIPPED;
            trip_d  = 1'b1;
            wcnt_d  = '0;
            ccnt_d  = '0;
            hcnt_d  = '0;
            if (trip_cnt_q != 16'hFFFF) begin
              trip_cnt_d = trip_cnt_q + 16'd1;
            end
          end else if (wcnt_q == WCNT_LAST) begin
            // The wrap beat belongs to the old window. Its clip, if any,
            // was already judged above, so the new window starts at zero.
            wcnt_d = '0;
            ccnt_d = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
            if (clip_flag) begin
              ccnt_d = ccnt_q + 1'b1;
            end
          end
        end

        S_TRIPPED: begin
          if (hcnt_q == HCNT_LAST) begin
            // The request is known high here, so re-arm straight into ACTIVE.
            state_d = S_ACTIVE;
            hcnt_d  = '0;
            wcnt_d  = '0;
            ccnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          wcnt_d  = '0;
          ccnt_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Flops. Asserting reset clears everything at once, including any hold-off
  // still in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge JESD_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dpd_q      <= '0;
      byp_q      <= '0;
      data_q     <= '0;
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      ccnt_q     <= '0;
      hcnt_q     <= '0;
      trip_q     <= 1'b0;
      trip_cnt_q <= '0;
      clip_cnt_q <= '0;
      ovf_led_q  <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      dpd_q      <= dpd_d;
      byp_q      <= byp_d;
      data_q     <= data_d;
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      ccnt_q     <= ccnt_d;
      hcnt_q     <= hcnt_d;
      trip_q     <= trip_d;
      trip_cnt_q <= trip_cnt_d;
      clip_cnt_q <= clip_cnt_d;
      ovf_led_q  <= ovf_led_d;
      req_q      <= req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.data_o     = data_q;
  assign bus.state_o    = state_q;
  assign bus.trip_o     = trip_q;
  assign bus.trip_cnt_o = trip_cnt_q;
  assign bus.clip_cnt_o = clip_cnt_q;
  assign bus.ovf_led_o  = ovf_led_q;

endmodule
